// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and the requester arbiter around it.
package alu_pkg;

    localparam int ALU_FUNCT_W = 3;
    localparam int NUM_FLAGS   = 6;

    // ALU function codes; all eight encodings are meaningful.
    typedef enum logic [ALU_FUNCT_W-1:0] {
        SUM         = 3'd0,
        SHIFT_LEFT  = 3'd1,
        SUB         = 3'd2,
        LOAD        = 3'd3,
        XOR         = 3'd4,
        SHIFT_RIGHT = 3'd5,
        NOT         = 3'd6,
        AND         = 3'd7
    } alu_op_e;

    // Bit positions inside the 6-bit flag vector.
    localparam int FLAG_OVF  = 5;
    localparam int FLAG_NEG  = 4;
    localparam int FLAG_ZERO = 3;
    localparam int FLAG_EQ   = 2;
    localparam int FLAG_GT   = 1;
    localparam int FLAG_LT   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Comparison flags treat a and b as signed values;
// overflow is the signed overflow of SUM/SUB and 0 for every other op.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_op_e                i_op,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
    output logic [WIDTH-1:0]       o_result,
    output logic [NUM_FLAGS-1:0]   o_flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] w_shamt;
    logic           w_ovf;

    assign w_shamt = i_b[SHW-1:0];

    // Result and signed overflow for the selected function.
    always_comb begin
        o_result = '0;
        w_ovf    = 1'b0;
        case (i_op)
            SUM: begin
                o_result = i_a + i_b;
                w_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            SHIFT_LEFT:  o_result = i_a << w_shamt;
            SUB: begin
                o_result = i_a - i_b;
                w_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            LOAD:        o_result = i_b;
            XOR:         o_result = i_a ^ i_b;
            SHIFT_RIGHT: o_result = i_a >> w_shamt;
            NOT:         o_result = ~i_a;
            AND:         o_result = i_a & i_b;
            default:     o_result = '0;
        endcase
    end

    // Status flags derived from the result and a signed operand compare.
    always_comb begin
        o_flags            = '0;
        o_flags[FLAG_OVF]  = w_ovf;
        o_flags[FLAG_NEG]  = o_result[WIDTH-1];
        o_flags[FLAG_ZERO] = (o_result == '0);
        o_flags[FLAG_EQ]   = (i_a == i_b);
        o_flags[FLAG_GT]   = ($signed(i_a) > $signed(i_b));
        o_flags[FLAG_LT]   = ($signed(i_a) < $signed(i_b));
    end

endmodule

// File: rtl/alu_arbiter_rr_grant.sv
// Round-robin pick: first asserted valid at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_grant #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan from farthest to nearest so the candidate closest to the pointer wins.
    always_comb begin
        logic [PTR_W-1:0] v_cand;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        v_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_cand = PTR_W'((32'(i_ptr) + 32'(k)) % NUM_REQ);
            if (i_valid[v_cand]) begin
                o_idx = v_cand;
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grants and a
// single operation in flight.
//
// state | meaning
// IDLE  | nothing in flight, any granted request is accepted
// EXEC  | operands registered, ALU evaluating this cycle
// RESP  | result held for the owner; drain may overlap with the next accept
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 64,
    parameter int FUNCT_W = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FUNCT_W-1:0] req_funct,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [NUM_FLAGS-1:0]       rsp_flags,
    output logic                       busy
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    arb_state_e           r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [FUNCT_W-1:0]   r_funct;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_result;
    logic [NUM_FLAGS-1:0] r_flags;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]     w_grant_idx;
    logic                 w_grant_any;
    logic                 w_drain;
    logic                 w_can_accept;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_alu_result;
    logic [NUM_FLAGS-1:0] w_alu_flags;

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_grant (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op     (alu_op_e'(r_funct[ALU_FUNCT_W-1:0])),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    // Only the owner's rsp_ready can retire the held response.
    assign w_drain      = (r_state == RESP) && rsp_ready[r_owner];
    assign w_can_accept = (r_state == IDLE) || w_drain;
    assign w_accept     = w_can_accept && w_grant_any;
    assign req_ready    = w_can_accept ? w_grant : '0;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign busy       = r_busy;

    // Sequencer: accept -> execute -> hold response until the owner drains it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_funct     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_funct     <= req_funct[w_grant_idx*FUNCT_W +: FUNCT_W];
                        r_a         <= req_a[w_grant_idx*WIDTH +: WIDTH];
                        r_b         <= req_b[w_grant_idx*WIDTH +: WIDTH];
                        r_owner     <= w_grant_idx;
                        r_ptr       <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;
                        r_state     <= EXEC;
                        r_busy      <= 1'b1;
                        r_rsp_valid <= '0;
                    end else if (w_drain) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= '0;
                    end
                end
                EXEC: begin
                    r_result    <= w_alu_result;
                    r_flags     <= w_alu_flags;
                    r_rsp_valid <= NUM_REQ'(1) << r_owner;
                    r_state     <= RESP;
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_rsp_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*3-1:0]   req_funct = '0;
    logic [NR*64-1:0]  req_a = '0;
    logic [NR*64-1:0]  req_b = '0;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready = '0;
    logic [63:0]       rsp_result;
    logic [5:0]        rsp_flags;
    logic              busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  f;
        logic [63:0] a;
        logic [63:0] b;
    } op_t;

    typedef struct {
        int          owner;
        logic [63:0] r;
        logic [5:0]  fl;
        int          due;
    } exp_t;

    op_t  opq[NR][$];
    exp_t expq[$];

    alu_arbiter #(.NUM_REQ(NR), .WIDTH(64), .FUNCT_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: exact 65-bit signed arithmetic decides overflow.
    function automatic void alu_model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output logic [5:0] fl);
        logic signed [64:0] wide;
        longint sa;
        longint sb;
        logic ovf;
        sa = a;
        sb = b;
        ovf = 1'b0;
        wide = '0;
        r = '0;
        case (f)
            3'd0: begin
                wide = $signed({a[63], a}) + $signed({b[63], b});
                r = wide[63:0];
                ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
            end
            3'd1: r = a << b[5:0];
            3'd2: begin
                wide = $signed({a[63], a}) - $signed({b[63], b});
                r = wide[63:0];
                ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
            end
            3'd3: r = b;
            3'd4: r = a ^ b;
            3'd5: r = a >> b[5:0];
            3'd6: r = ~a;
            default: r = a & b;
        endcase
        fl = {ovf, r[63], (r == 64'd0), (sa == sb), (sa > sb), (sa < sb)};
    endfunction

    task automatic set_req(input int r, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        req_funct[r*3 +: 3] = f;
        req_a[r*64 +: 64]   = a;
        req_b[r*64 +: 64]   = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One isolated operation: grant, one EXEC cycle, response, drain.
    task automatic run_single(input int r, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                              input string tag, output logic [63:0] o_r, output logic [5:0] o_f);
        logic [63:0] er;
        logic [5:0]  ef;
        int n;
        alu_model(f, a, b, er, ef);
        @(negedge clk);
        set_req(r, f, a, b);
        req_valid = NR'(1) << r;
        rsp_ready = '0;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_grant"}, 64'(req_ready), 64'(NR'(1) << r));
        @(negedge clk);
        req_valid = '0;
        #1;
        check({tag, "_exec_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_exec_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(NR'(1) << r));
        check({tag, "_result"}, rsp_result, er);
        check({tag, "_flags"}, 64'(rsp_flags), 64'(ef));
        o_r = rsp_result;
        o_f = rsp_flags;
        rsp_ready = NR'(1) << r;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        check({tag, "_drained"}, 64'(rsp_valid), 64'd0);
    endtask

    function automatic op_t rand_op();
        op_t o;
        logic [63:0] edges [4];
        edges[0] = 64'h0;
        edges[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        edges[2] = 64'h8000_0000_0000_0000;
        edges[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        o.f = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: begin o.a = {$urandom, $urandom}; o.b = {$urandom, $urandom}; end
            1: begin o.a = 64'($urandom_range(0, 100)); o.b = 64'($urandom_range(0, 100)); end
            2: begin o.a = {$urandom, $urandom}; o.b = o.a; end
            default: begin o.a = edges[$urandom_range(0, 3)]; o.b = edges[$urandom_range(0, 3)]; end
        endcase
        return o;
    endfunction

    initial begin
        logic [63:0] er, orr;
        logic [5:0]  ef, off;
        logic [NR-1:0] want, exp_rv, exp_rr;
        op_t  op;
        int   n, pick, m_ptr, c;
        logic drain, can;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_result", rsp_result, 64'd0);
        check("reset_flags", 64'(rsp_flags), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic SUM on requester 0
        run_single(0, SUM, 64'd12, 64'd25, "sum12_25", orr, off);
        check("sum12_25_const", orr, 64'd37);

        // Contention from reset: req0 first, req1 on req0's drain, then req0 again
        do_reset();
        @(negedge clk);
        set_req(0, SUB, 64'd12, 64'd25);
        set_req(1, AND, 64'd12, 64'd25);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        check("cont_grant0", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        check("cont_exec_block", 64'(req_ready), 64'b00);
        @(negedge clk);
        #1;
        alu_model(SUB, 64'd12, 64'd25, er, ef);
        check("cont_rsp0_valid", 64'(rsp_valid), 64'b01);
        check("cont_rsp0_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFF3);
        check("cont_rsp0_flags", 64'(rsp_flags), 64'(ef));
        check("cont_rsp0_neg", 64'(rsp_flags[FLAG_NEG]), 64'd1);
        check("cont_grant1_on_drain", 64'(req_ready), 64'b10);
        @(negedge clk);
        set_req(0, SUM, 64'd1, 64'd2);
        set_req(1, XOR, 64'd5, 64'd3);
        req_valid = 2'b11;
        #1;
        check("cont_exec1_rsp_valid", 64'(rsp_valid), 64'b00);
        check("cont_exec1_block", 64'(req_ready), 64'b00);
        @(negedge clk);
        #1;
        check("cont_rsp1_valid", 64'(rsp_valid), 64'b10);
        check("cont_rsp1_result", rsp_result, 64'd8);
        check("cont_rr_back_to_0", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rsp_ready = '0;
        #1;
        check("cont_flushed", 64'(rsp_valid), 64'd0);

        // Held response on requester 1 while another requester waits
        @(negedge clk);
        set_req(1, SUB, 64'd54, 64'd54);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        check("hold_grant1", 64'(req_ready), 64'b10);
        @(negedge clk);
        set_req(0, SUM, 64'd1, 64'd1);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        alu_model(SUB, 64'd54, 64'd54, er, ef);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("hold_rsp_valid", 64'(rsp_valid), 64'b10);
            check("hold_result", rsp_result, 64'd0);
            check("hold_flags", 64'(rsp_flags), 64'(ef));
            check("hold_zero_eq", 64'(rsp_flags[FLAG_ZERO:FLAG_EQ]), 64'b11);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        #1;
        check("hold_drain_accept", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("hold_next_exec", 64'(rsp_valid), 64'd0);
        check("hold_next_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        check("hold_next_rsp", 64'(rsp_valid), 64'b01);
        check("hold_next_result", rsp_result, 64'd2);
        @(negedge clk);
        rsp_ready = '0;
        #1;
        check("hold_done", 64'(rsp_valid), 64'd0);

        // Signed overflow boundaries
        run_single(0, SUM, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, "ovf_sum", orr, off);
        check("ovf_sum_const", orr, 64'h8000_0000_0000_0002);
        check("ovf_sum_ovf", 64'(off[FLAG_OVF]), 64'd1);
        check("ovf_sum_neg", 64'(off[FLAG_NEG]), 64'd1);
        run_single(0, SUB, 64'h8000_0000_0000_0000, 64'd3, "ovf_sub", orr, off);
        check("ovf_sub_ovf", 64'(off[FLAG_OVF]), 64'd1);
        run_single(1, SHIFT_RIGHT, 64'hF000_0000_0000_0000, 64'd68, "shr", orr, off);
        run_single(1, NOT, 64'h0, 64'd0, "not", orr, off);

        // Reset during EXEC aborts the operation
        @(negedge clk);
        set_req(1, SUM, 64'd100, 64'd1);
        req_valid = 2'b10;
        #1;
        check("abort_grant1", 64'(req_ready), 64'b10);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("abort_in_exec", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_req(0, LOAD, 64'd0, 64'd9);
        set_req(1, LOAD, 64'd0, 64'd7);
        req_valid = 2'b11;
        #1;
        check("abort_prio0", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        rsp_ready = '0;

        // Randomized: req0 always valid, req1 pulses, random rsp_ready
        do_reset();
        m_ptr = 0;
        for (int k = 0; k < 24; k++) opq[0].push_back(rand_op());
        for (int k = 0; k < 12; k++) opq[1].push_back(rand_op());
        want = 2'b01;
        n = 0;
        while ((opq[0].size() != 0 || opq[1].size() != 0 || expq.size() != 0) && n < 3000) begin
            @(negedge clk);
            if (!want[1] && $urandom_range(0, 2) == 0) want[1] = 1'b1;
            else if (want[1] && $urandom_range(0, 7) == 0) want[1] = 1'b0;
            want[0] = 1'b1;
            for (int r = 0; r < NR; r++) begin
                if (want[r] && opq[r].size() != 0) begin
                    set_req(r, opq[r][0].f, opq[r][0].a, opq[r][0].b);
                    req_valid[r] = 1'b1;
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
            rsp_ready = NR'($urandom_range(0, 3));
            #1;
            exp_rv = '0;
            if (expq.size() != 0 && n >= expq[0].due) exp_rv[expq[0].owner] = 1'b1;
            check("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("rnd_busy", 64'(busy), 64'(expq.size() != 0));
            if (exp_rv != 0) begin
                check("rnd_result", rsp_result, expq[0].r);
                check("rnd_flags", 64'(rsp_flags), 64'(expq[0].fl));
            end
            drain = (exp_rv != 0) && rsp_ready[expq[0].owner];
            can = (expq.size() == 0) || drain;
            pick = -1;
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (pick < 0 && req_valid[c]) pick = c;
            end
            exp_rr = (can && pick >= 0) ? (NR'(1) << pick) : '0;
            check("rnd_req_ready", 64'(req_ready), 64'(exp_rr));
            @(posedge clk);
            if (drain) void'(expq.pop_front());
            if (exp_rr != 0) begin
                op = opq[pick].pop_front();
                alu_model(op.f, op.a, op.b, er, ef);
                expq.push_back('{pick, er, ef, n + 2});
                m_ptr = (pick + 1) % NR;
                if (pick == 1) want[1] = 1'b0;
            end
            n++;
        end
        check("rnd_completed", 64'(n < 3000), 64'd1);
        req_valid = '0;
        rsp_ready = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
